chi_inv_iter: RTL and testbench



---
 rtl/chi_pkg.sv | 32 +++
 rtl/chi_inv_plane.sv | 21 ++
 rtl/chi_inv_iter.sv | 82 ++++++++
 tb/tb_chi_inv_iter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/chi_pkg.sv
// Shared types and row functions for the Keccak chi / inverse-chi datapath.
// chi_row    : forward chi on one 5-bit row, b[x] = a[x] ^ (~a[x+1] & a[x+2]).
// chi_inv_row: exact inverse of chi_row over all 32 row values.
package chi_pkg;
  localparam int CHI_LANE_W = 64;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} chi_state_e;

  // Indexed [x][y][z]: st[x][y] is one lane.
  typedef logic [4:0][4:0][CHI_LANE_W-1:0] chi_state_t;

  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] b;
    b[0] = a[0] ^ (~a[1] & a[2]);
    b[1] = a[1] ^ (~a[2] & a[3]);
    b[2] = a[2] ^ (~a[3] & a[4]);
    b[3] = a[3] ^ (~a[4] & a[0]);
    b[4] = a[4] ^ (~a[0] & a[1]);
    return b;
  endfunction

  // Closed-form inverse: a[x] = b[x] ^ (~b[x+1] & (b[x+2] ^ (~b[x+3] & b[x+4])))
  function automatic logic [4:0] chi_inv_row(input logic [4:0] b);
    logic [4:0] a;
    a[0] = b[0] ^ (~b[1] & (b[2] ^ (~b[3] & b[4])));
    a[1] = b[1] ^ (~b[2] & (b[3] ^ (~b[4] & b[0])));
    a[2] = b[2] ^ (~b[3] & (b[4] ^ (~b[0] & b[1])));
    a[3] = b[3] ^ (~b[4] & (b[0] ^ (~b[1] & b[2])));
    a[4] = b[4] ^ (~b[0] & (b[1] ^ (~b[2] & b[3])));
    return a;
  endfunction
endpackage

// File: rtl/chi_inv_plane.sv
// Combinational inverse chi over one plane (fixed y): LANE_W independent rows.
// i_lanes : five input lanes of the plane, indexed [x][z]
// o_lanes : five recovered lanes, indexed [x][z]
module chi_inv_plane
  import chi_pkg::*;
#(
  parameter int LANE_W = CHI_LANE_W
) (
  input  logic [4:0][LANE_W-1:0] i_lanes,
  output logic [4:0][LANE_W-1:0] o_lanes
);
  for (genvar z = 0; z < LANE_W; z++) begin : g_row
    logic [4:0] w_row;
    logic [4:0] w_inv;
    assign w_row = {i_lanes[4][z], i_lanes[3][z], i_lanes[2][z], i_lanes[1][z], i_lanes[0][z]};
    assign w_inv = chi_inv_row(w_row);
    for (genvar x = 0; x < 5; x++) begin : g_x
      assign o_lanes[x][z] = w_inv[x];
    end
  end
endmodule

// File: rtl/chi_inv_iter.sv
// Iterative inverse chi over a full 5x5xLANE_W state, one plane per cycle.
// clk, reset      : clock, asynchronous active-low reset
// in_valid/ready  : input handshake, Ab_in = chi-output state [x][y][z]
// out_valid/ready : output handshake, A_out = recovered pre-chi state
// busy            : high while an operation is in BUSY or DONE
module chi_inv_iter
  import chi_pkg::*;
#(
  parameter int LANE_W = CHI_LANE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0][4:0][LANE_W-1:0]  Ab_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0][4:0][LANE_W-1:0]  A_out,
  output logic                         busy
);
  chi_state_e                  r_state, w_next;
  logic [2:0]                  r_cnt;
  logic [4:0][4:0][LANE_W-1:0] r_st;
  logic [4:0][LANE_W-1:0]      w_plane_in, w_plane_out;

  // Single shared inverter, fed by the plane selected by the counter.
  for (genvar x = 0; x < 5; x++) begin : g_mux
    assign w_plane_in[x] = r_st[x][r_cnt];
  end

  chi_inv_plane #(.LANE_W(LANE_W)) u_plane (
    .i_lanes (w_plane_in),
    .o_lanes (w_plane_out)
  );

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (r_cnt == 3'd4) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_st    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_st  <= Ab_in;
        r_cnt <= 3'd0;
      end else if (r_state == BUSY) begin
        // In-place update of plane y=cnt; other planes hold.
        r_st[0][r_cnt] <= w_plane_out[0];
        r_st[1][r_cnt] <= w_plane_out[1];
        r_st[2][r_cnt] <= w_plane_out[2];
        r_st[3][r_cnt] <= w_plane_out[3];
        r_st[4][r_cnt] <= w_plane_out[4];
        r_cnt          <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
      end
    end
  end

  assign A_out = r_st;
endmodule

// File: tb/tb_chi_inv_iter.sv
// Self-checking bench for chi_inv_iter: directed steps, scoreboard of expected
// pre-chi states pushed on accept and popped on the output handshake.
module tb_chi_inv_iter;
  import chi_pkg::*;

  localparam int W = CHI_LANE_W;
  typedef logic [4:0][4:0][W-1:0] st_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  st_t  Ab_in = '0;
  st_t  A_out;

  int   checks = 0;
  int   errors = 0;
  st_t  sb_q[$];

  always #5 clk = ~clk;

  chi_inv_iter #(.LANE_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Ab_in     (Ab_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_out     (A_out),
    .busy      (busy)
  );

  function automatic logic [2:0] m5(input int v);
    return 3'(v % 5);
  endfunction

  // Bench-side forward chi on a row and on a whole state.
  function automatic logic [4:0] tb_chi5(input logic [4:0] a);
    logic [4:0] b;
    for (int i = 0; i < 5; i++)
      b[m5(i)] = a[m5(i)] ^ (~a[m5(i+1)] & a[m5(i+2)]);
    return b;
  endfunction

  function automatic st_t tb_chi_state(input st_t a);
    st_t b;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[m5(x)][m5(y)] = a[m5(x)][m5(y)] ^ (~a[m5(x+1)][m5(y)] & a[m5(x+2)][m5(y)]);
    return b;
  endfunction

  // Preimage of a row by exhaustive search over the forward map.
  function automatic logic [4:0] tb_pre5(input logic [4:0] v);
    for (int a = 0; a < 32; a++)
      if (tb_chi5(5'(a)) == v) return 5'(a);
    return 5'd0;
  endfunction

  function automatic st_t row_state(input logic [4:0] v);
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[m5(x)][m5(y)] = {W{v[m5(x)]}};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input st_t obs, input st_t exp);
    int fx, fy;
    checks++;
    assert (obs === exp) else begin
      errors++;
      fx = 0; fy = 0;
      for (int x = 4; x >= 0; x--)
        for (int y = 4; y >= 0; y--)
          if (obs[m5(x)][m5(y)] !== exp[m5(x)][m5(y)]) begin fx = x; fy = y; end
      $error("FAIL %s lane[%0d][%0d]: got %h expected %h", tag, fx, fy,
             obs[m5(fx)][m5(fy)], exp[m5(fx)][m5(fy)]);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge, in_valid still high.
  task automatic drive_accept(input st_t s);
    int n = 0;
    Ab_in    = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic pop_cmp(input string tag);
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb_empty: got 0 entries expected >0", tag);
    end
    if (sb_q.size() > 0) chk_st(tag, A_out, sb_q.pop_front());
  endtask

  // Full operation with latency check and optional output stalls.
  task automatic run_op(input st_t s, input st_t exp, input int stalls, input string tag);
    int   lat;
    st_t  held;
    drive_accept(s);
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;  // negedge after accept edge N; lat=k at negedge after N+k
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, 64'(lat), 64'd5);
    if (stalls > 0) begin
      held = A_out;
      for (int k = 0; k < stalls; k++) begin
        @(negedge clk);
        chk_st({tag, "_stall_hold"}, A_out, held);
        chk({tag, "_stall_inrdy_vld"}, {62'd0, in_ready, out_valid}, 64'd1);
      end
    end
    out_ready = 1'b1;
    pop_cmp(tag);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t s, e, a, b;
    int  n;
    logic saw_vld;

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_flags", {61'd0, in_ready, out_valid, busy}, 64'b100);
    chk_st("rst_state", A_out, '0);

    // Single row
    s = '0; s[0][2][0] = 1'b1; s[3][2][0] = 1'b1;
    e = '0; e[0][2][0] = 1'b1;
    run_op(s, e, 0, "single_row");

    // All ones / all zeros
    run_op({25{64'hFFFF_FFFF_FFFF_FFFF}}, {25{64'hFFFF_FFFF_FFFF_FFFF}}, 0, "all_ones");
    run_op('0, '0, 0, "all_zeros");

    // Every row equal to v, for all 32 v
    for (int v = 0; v < 32; v++)
      run_op(row_state(5'(v)), row_state(tb_pre5(5'(v))), 0, "row_exh");

    // Back-pressure: second state held on in_valid during BUSY/DONE
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        a[m5(x)][m5(y)] = {$urandom, $urandom};
        b[m5(x)][m5(y)] = {$urandom, $urandom};
      end
    drive_accept(tb_chi_state(a));
    sb_q.push_back(a);
    @(negedge clk);
    Ab_in = tb_chi_state(b);
    n = 0;
    while (!out_valid && n < 50) begin
      chk("bp_inrdy_busy", 64'(in_ready), 64'd0);
      @(negedge clk); n++;
    end
    chk("bp_done_reached", 64'(out_valid), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("bp_inrdy_done", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    pop_cmp("bp_first");
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_flags", {62'd0, in_ready, busy}, 64'b10);
    sb_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    out_ready = 1'b1;
    pop_cmp("bp_second");
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during BUSY at cnt==2
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) a[m5(x)][m5(y)] = {$urandom, $urandom};
    drive_accept(tb_chi_state(a));
    sb_q.push_back(a);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_flags", {62'd0, out_valid, busy}, 64'd0);
    chk_st("midrst_state", A_out, '0);
    void'(sb_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_inrdy", 64'(in_ready), 64'd1);
    saw_vld = 1'b0;
    repeat (8) begin @(negedge clk); saw_vld |= out_valid; end
    chk("midrst_no_vld", 64'(saw_vld), 64'd0);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) a[m5(x)][m5(y)] = {$urandom, $urandom};
    run_op(tb_chi_state(a), a, 1, "midrst_fresh");

    // Random round trip with output stalls
    for (int t = 0; t < 200; t++) begin
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) a[m5(x)][m5(y)] = {$urandom, $urandom};
      run_op(tb_chi_state(a), a, int'($urandom_range(0, 3)), "rand");
    end

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
